mailbox_owner_ctrl: RTL and testbench
=====================================

MAILBOX_OWNER_CTRL -- requirements
Module: mailbox_owner_ctrl

Interface
REQ-001 SHALL have parameter QUOTA_W, default 12, width of the message-quota counter.
REQ-002 SHALL have parameter TIME_W, default 16, width of the ownership-timeout counter.
REQ-003 SHALL have port clk, input, 1, the single block clock; clock and reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset sampled on rising clk.
REQ-005 SHALL have port req, input, 3, ownership request from ctrl0/ctrl1/ctrl2 (bit i = ctrl i).
REQ-006 SHALL have port yield, input, 3, voluntary release from ctrl i; effective only for the current owner.
REQ-007 SHALL have port access, input, 1, one-cycle strobe per completed owner read/write on the shared data queue.
REQ-008 SHALL have port force_revoke, input, 1, revoke request from the fixed (OS) side.
REQ-009 SHALL have port quota_cfg, input, QUOTA_W, message quota loaded at grant; 0 = unlimited.
REQ-010 SHALL have port timeout_cfg, input, TIME_W, cycle limit loaded at grant; 0 = unlimited.
REQ-011 SHALL have port owner_valid, output, 1, high while a ctrl port owns the queue.
REQ-012 SHALL have port owner_id, output, 2, index of current or most recent owner.
REQ-013 SHALL have port quota_left, output, QUOTA_W, remaining accesses.
REQ-014 SHALL have port time_left, output, TIME_W, remaining cycles.
REQ-015 SHALL have port irq, output, 3, one-cycle grant pulse to ctrl i.
REQ-016 SHALL have port irq_fixed, output, 1, one-cycle pulse to fixed side on every revoke.
REQ-017 SHALL have port revoke_reason, output, 2, 0 quota, 1 timeout, 2 yield, 3 force; held until next revoke.

Function
REQ-018 SHALL implement states IDLE, ACTIVE, REVOKE.
REQ-019 SHALL, in IDLE with req!=0, grant round-robin starting at (last_owner+1) mod 3, enter ACTIVE next edge.
REQ-020 SHALL, on grant edge, set owner_valid=1, latch owner_id, load quota_left=quota_cfg and time_left=timeout_cfg, pulse irq[owner_id] for exactly the first ACTIVE cycle.
REQ-021 SHALL give grant latency of one cycle: req sampled at edge N -> owner_valid=1 after edge N.
REQ-022 SHALL, in ACTIVE, decrement time_left each cycle when timeout_cfg latched !=0, and decrement quota_left on each access when quota latched !=0; both saturate at 0.
REQ-023 SHALL detect revoke in ACTIVE when: force_revoke; yield[owner_id]; access with quota_left==1 (limited); time_left==1 (limited).
REQ-024 SHALL, on multiple simultaneous revoke causes, record one revoke with priority force > yield > quota > timeout.
REQ-025 SHALL, on revoke detect, enter REVOKE next edge: owner_valid=0, irq_fixed=1 for that one cycle, revoke_reason updated, last_owner<=owner_id.
REQ-026 SHALL return from REVOKE to IDLE unconditionally after one cycle; earliest next grant is two edges after REVOKE entry.
REQ-027 SHALL ignore access, yield and force_revoke outside ACTIVE, and yield from non-owners.
REQ-028 SHALL NOT revoke when the owner deasserts req during ACTIVE; req changes in ACTIVE are ignored.
REQ-029 SHALL ignore quota_cfg/timeout_cfg changes during ACTIVE.
REQ-030 SHALL let a revoked owner regain ownership only when no other requester is asserted (round-robin fairness).

Reset
REQ-031 SHALL, with resetn=0 at an edge, force state IDLE, owner_valid=0, owner_id=0, quota_left=0, time_left=0, irq=0, irq_fixed=0, revoke_reason=0, last_owner=2.
REQ-032 SHALL abort an ACTIVE ownership on reset without irq_fixed pulse.
REQ-033 SHALL make first grant after reset favour ctrl0 when all req bits set.

Verification
REQ-034 SHALL verify: req=3'b111 after reset -> owner_id=0, irq=3'b001 one cycle; yield=001 -> irq_fixed pulse, reason=2; next grant owner_id=1, then 2, then 0.
REQ-035 SHALL verify: quota_cfg=3, timeout_cfg=0, 3 access strobes -> quota_left 3,2,1, revoke after third, reason=0.
REQ-036 SHALL verify: quota_cfg=0, timeout_cfg=5, no access -> owner_valid high exactly 5 cycles, reason=1.
REQ-037 SHALL verify: force_revoke, yield[owner] and final access same cycle -> single irq_fixed pulse, reason=3.
REQ-038 SHALL verify: resetn=0 mid-ACTIVE -> all outputs at reset values next cycle, no irq_fixed; yield from non-owner -> no effect.

Source files
------------

// File: rtl/mailbox_owner_ctrl.sv
// Mailbox ownership controller: arbitrates the shared data queue between three
// ctrl ports with round-robin grants, per-grant access quota and cycle timeout,
// and reports every revoke (with its cause) to the fixed side.
module mailbox_owner_ctrl #(
    parameter int QUOTA_W = 12,
    parameter int TIME_W  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [2:0]         req,
    input  logic [2:0]         yield,
    input  logic               access,
    input  logic               force_revoke,
    input  logic [QUOTA_W-1:0] quota_cfg,
    input  logic [TIME_W-1:0]  timeout_cfg,
    output logic               owner_valid,
    output logic [1:0]         owner_id,
    output logic [QUOTA_W-1:0] quota_left,
    output logic [TIME_W-1:0]  time_left,
    output logic [2:0]         irq,
    output logic               irq_fixed,
    output logic [1:0]         revoke_reason
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REVOKE = 2'd2
    } state_t;

    localparam logic [1:0] REASON_QUOTA   = 2'd0;
    localparam logic [1:0] REASON_TIMEOUT = 2'd1;
    localparam logic [1:0] REASON_YIELD   = 2'd2;
    localparam logic [1:0] REASON_FORCE   = 2'd3;

    state_t     state;
    logic [1:0] last_owner;
    logic       quota_lim;   // quota latched at grant was non-zero
    logic       time_lim;    // timeout latched at grant was non-zero

    logic [1:0] pick0, pick1, pick2;
    logic       grant_found;
    logic [1:0] grant_id;

    // Round-robin search order starts just after the most recent owner.
    always_comb begin
        pick0 = 2'd0;
        pick1 = 2'd1;
        pick2 = 2'd2;
        case (last_owner)
            2'd0: begin pick0 = 2'd1; pick1 = 2'd2; pick2 = 2'd0; end
            2'd1: begin pick0 = 2'd2; pick1 = 2'd0; pick2 = 2'd1; end
            default: begin pick0 = 2'd0; pick1 = 2'd1; pick2 = 2'd2; end
        endcase
        grant_found = 1'b1;
        grant_id    = pick0;
        if (req[pick0])      grant_id = pick0;
        else if (req[pick1]) grant_id = pick1;
        else if (req[pick2]) grant_id = pick2;
        else                 grant_found = 1'b0;
    end

    logic       owner_yield;
    logic       quota_hit;
    logic       time_hit;
    logic       revoke_hit;
    logic [1:0] reason_next;

    // Revoke causes seen by the current owner, resolved force > yield > quota > timeout.
    always_comb begin
        owner_yield = yield[owner_id];
        quota_hit   = access && quota_lim && (quota_left == QUOTA_W'(1));
        time_hit    = time_lim && (time_left == TIME_W'(1));
        revoke_hit  = force_revoke || owner_yield || quota_hit || time_hit;
        if (force_revoke)     reason_next = REASON_FORCE;
        else if (owner_yield) reason_next = REASON_YIELD;
        else if (quota_hit)   reason_next = REASON_QUOTA;
        else                  reason_next = REASON_TIMEOUT;
    end

    // Ownership FSM with registered outputs; irq/irq_fixed are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            last_owner    <= 2'd2;
            quota_lim     <= 1'b0;
            time_lim      <= 1'b0;
            owner_valid   <= 1'b0;
            owner_id      <= 2'd0;
            quota_left    <= '0;
            time_left     <= '0;
            irq           <= 3'b000;
            irq_fixed     <= 1'b0;
            revoke_reason <= 2'd0;
        end else begin
            irq       <= 3'b000;
            irq_fixed <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state       <= ACTIVE;
                        owner_valid <= 1'b1;
                        owner_id    <= grant_id;
                        quota_left  <= quota_cfg;
                        time_left   <= timeout_cfg;
                        quota_lim   <= |quota_cfg;
                        time_lim    <= |timeout_cfg;
                        irq         <= 3'b001 << grant_id;
                    end
                end
                ACTIVE: begin
                    if (time_lim && (time_left != '0))
                        time_left <= time_left - TIME_W'(1);
                    if (access && quota_lim && (quota_left != '0))
                        quota_left <= quota_left - QUOTA_W'(1);
                    if (revoke_hit) begin
                        state         <= REVOKE;
                        owner_valid   <= 1'b0;
                        irq_fixed     <= 1'b1;
                        revoke_reason <= reason_next;
                        last_owner    <= owner_id;
                    end
                end
                REVOKE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mailbox_owner_ctrl.sv
// Self-checking bench for mailbox_owner_ctrl: directed scenarios plus random
// traffic compared every cycle against a behavioural ownership model.
module tb_mailbox_owner_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [2:0]  yield;
    logic        access;
    logic        force_revoke;
    logic [11:0] quota_cfg;
    logic [15:0] timeout_cfg;
    logic        owner_valid;
    logic [1:0]  owner_id;
    logic [11:0] quota_left;
    logic [15:0] time_left;
    logic [2:0]  irq;
    logic        irq_fixed;
    logic [1:0]  revoke_reason;

    int n_checks = 0;
    int n_errors = 0;

    mailbox_owner_ctrl #(.QUOTA_W(12), .TIME_W(16)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req           (req),
        .yield         (yield),
        .access        (access),
        .force_revoke  (force_revoke),
        .quota_cfg     (quota_cfg),
        .timeout_cfg   (timeout_cfg),
        .owner_valid   (owner_valid),
        .owner_id      (owner_id),
        .quota_left    (quota_left),
        .time_left     (time_left),
        .irq           (irq),
        .irq_fixed     (irq_fixed),
        .revoke_reason (revoke_reason)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the queue, how much budget remains, and a
    // one-cycle hold-off after every revoke.
    bit m_owned;
    int m_holdoff;
    int m_owner;
    int m_last;
    int m_quota, m_time;
    bit m_qlimited, m_tlimited;
    int m_irq;
    bit m_irqf;
    int m_reason;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit causes_force, causes_yield, causes_quota, causes_time;
        m_irq  = 0;
        m_irqf = 0;
        if (!resetn) begin
            m_owned = 0; m_holdoff = 0; m_owner = 0; m_last = 2;
            m_quota = 0; m_time = 0; m_qlimited = 0; m_tlimited = 0;
            m_reason = 0;
        end else if (m_holdoff > 0) begin
            m_holdoff = 0;
        end else if (m_owned) begin
            causes_force = force_revoke;
            causes_yield = yield[m_owner];
            causes_quota = access && m_qlimited && (m_quota == 1);
            causes_time  = m_tlimited && (m_time == 1);
            if (m_tlimited && m_time > 0) m_time = m_time - 1;
            if (access && m_qlimited && m_quota > 0) m_quota = m_quota - 1;
            if (causes_force || causes_yield || causes_quota || causes_time) begin
                m_owned   = 0;
                m_holdoff = 1;
                m_irqf    = 1;
                m_last    = m_owner;
                if (causes_force)      m_reason = 3;
                else if (causes_yield) m_reason = 2;
                else if (causes_quota) m_reason = 0;
                else                   m_reason = 1;
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int cand;
                cand = (m_last + k) % 3;
                if (!m_owned && req[cand]) begin
                    m_owned    = 1;
                    m_owner    = cand;
                    m_quota    = quota_cfg;
                    m_time     = timeout_cfg;
                    m_qlimited = (quota_cfg != 0);
                    m_tlimited = (timeout_cfg != 0);
                    m_irq      = 1 << cand;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("owner_valid",   {31'd0, owner_valid},   m_owned);
        check_eq("owner_id",      {30'd0, owner_id},      m_owner);
        check_eq("quota_left",    {20'd0, quota_left},    m_quota);
        check_eq("time_left",     {16'd0, time_left},     m_time);
        check_eq("irq",           {29'd0, irq},           m_irq);
        check_eq("irq_fixed",     {31'd0, irq_fixed},     m_irqf);
        check_eq("revoke_reason", {30'd0, revoke_reason}, m_reason);
    endtask

    // One clock: drive on the falling edge, step the model at the rising
    // edge, compare shortly after.
    task automatic cyc(input logic rn, input logic [2:0] rq, input logic [2:0] yl,
                       input logic ac, input logic fr,
                       input logic [11:0] qc, input logic [15:0] tc);
        @(negedge clk);
        resetn = rn; req = rq; yield = yl; access = ac; force_revoke = fr;
        quota_cfg = qc; timeout_cfg = tc;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
    endtask

    initial begin
        int cnt;
        resetn = 1'b0; req = '0; yield = '0; access = 1'b0; force_revoke = 1'b0;
        quota_cfg = '0; timeout_cfg = '0;

        // Reset state
        cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        cyc(1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("rst_valid", {31'd0, owner_valid}, 32'd0);

        // Round-robin rotation after reset, yield-driven
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("rr_first_id", {30'd0, owner_id}, 32'd0);
        check_eq("rr_first_irq", {29'd0, irq}, 32'd1);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("irq_one_cycle", {29'd0, irq}, 32'd0);
        cyc(1'b1, 3'b111, 3'b001, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("yield_irqf", {31'd0, irq_fixed}, 32'd1);
        check_eq("yield_reason", {30'd0, revoke_reason}, 32'd2);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("rr_second_id", {30'd0, owner_id}, 32'd1);
        check_eq("rr_second_irq", {29'd0, irq}, 32'd2);
        cyc(1'b1, 3'b111, 3'b010, 1'b0, 1'b0, 12'd0, 16'd0);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("rr_third_id", {30'd0, owner_id}, 32'd2);
        cyc(1'b1, 3'b111, 3'b100, 1'b0, 1'b0, 12'd0, 16'd0);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        cyc(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("rr_wrap_id", {30'd0, owner_id}, 32'd0);
        cyc(1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 12'd0, 16'd0);
        idle_cyc();

        // Quota of 3 accesses; sole requester regains ownership
        cyc(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 12'd3, 16'd0);
        check_eq("quota_id", {30'd0, owner_id}, 32'd0);
        check_eq("quota_3", {20'd0, quota_left}, 32'd3);
        cyc(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 12'd9, 16'd9);
        check_eq("quota_2", {20'd0, quota_left}, 32'd2);
        cyc(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 12'd9, 16'd9);
        check_eq("quota_1", {20'd0, quota_left}, 32'd1);
        cyc(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 12'd9, 16'd9);
        check_eq("quota_revoke", {31'd0, owner_valid}, 32'd0);
        check_eq("quota_reason", {30'd0, revoke_reason}, 32'd0);
        idle_cyc();

        // Timeout of 5 cycles with no access
        cyc(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 12'd0, 16'd5);
        cnt = 0;
        for (int i = 0; i < 20 && owner_valid; i++) begin
            cnt++;
            idle_cyc();
        end
        check_eq("timeout_cycles", cnt, 32'd5);
        check_eq("timeout_reason", {30'd0, revoke_reason}, 32'd1);
        idle_cyc();

        // Simultaneous force, owner yield and final access
        cyc(1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 12'd1, 16'd0);
        check_eq("multi_id", {30'd0, owner_id}, 32'd1);
        cyc(1'b1, 3'b000, 3'b010, 1'b1, 1'b1, 12'd0, 16'd0);
        check_eq("multi_irqf", {31'd0, irq_fixed}, 32'd1);
        check_eq("multi_reason", {30'd0, revoke_reason}, 32'd3);
        idle_cyc();
        check_eq("multi_single_pulse", {31'd0, irq_fixed}, 32'd0);

        // Non-owner yield ignored, then reset mid-ownership
        cyc(1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 12'd7, 16'd30);
        cyc(1'b1, 3'b000, 3'b011, 1'b0, 1'b0, 12'd0, 16'd0);
        check_eq("nonowner_yield", {31'd0, owner_valid}, 32'd1);
        cyc(1'b0, 3'b111, 3'b100, 1'b1, 1'b1, 12'd0, 16'd0);
        check_eq("rst_mid_valid", {31'd0, owner_valid}, 32'd0);
        check_eq("rst_mid_irqf", {31'd0, irq_fixed}, 32'd0);
        check_eq("rst_mid_time", {16'd0, time_left}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic rn, ac, fr;
            logic [2:0] rq, yl;
            logic [11:0] qc;
            logic [15:0] tc;
            rn = ($urandom_range(0, 299) != 0);
            rq = 3'($urandom_range(0, 7));
            yl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            ac = 1'($urandom_range(0, 1));
            fr = ($urandom_range(0, 29) == 0);
            qc = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 5));
            tc = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            cyc(rn, rq, yl, ac, fr, qc, tc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
